// File: rtl/store_ctrl_pkg.sv
// Shared types and constants for the store-buffer drain controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package store_ctrl_pkg;

  // Default width of one store-buffer entry / cache request payload.
  localparam int ENTRY_W_DEF = 56;

  // Entry field offsets, used when inspecting payloads in debug and checks.
  localparam int TAG_HI = 55;
  localparam int TAG_LO = 41;
  localparam int WAY_HI = 35;
  localparam int WAY_LO = 34;

  // Drain sequencer states: one store outstanding at a time.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RETIRE   = 2'd3
  } drain_state_e;

  // Extract the cache tag of an entry.
  function automatic logic [TAG_HI-TAG_LO:0] entry_tag(input logic [ENTRY_W_DEF-1:0] e);
    return e[TAG_HI:TAG_LO];
  endfunction

  // Extract the target way of an entry.
  function automatic logic [WAY_HI-WAY_LO:0] entry_way(input logic [ENTRY_W_DEF-1:0] e);
    return e[WAY_HI:WAY_LO];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear; clear has priority over increment.
// Latency: count visible the cycle after inc/clr.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, synchronously cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/store_drain_ctrl.sv
// Drains store-buffer entries into the data cache and shares its request port with loads.
// Latency: decision cycle N, store request N+1, pop at N+3 with a zero-wait cache.
// Backpressure: store payload held until dc_req_ready; loads blocked while a store is in flight.
module store_drain_ctrl
  import store_ctrl_pkg::*;
#(
  parameter int ENTRY_W           = ENTRY_W_DEF,
  parameter int IDLE_DRAIN_CYCLES = 4,
  parameter int STARVE_LIMIT      = 8,
  parameter int CNT_W             = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sb_empty,
  input  logic               sb_full,
  input  logic [ENTRY_W-1:0] sb_oldest_info,
  output logic               sb_get_oldest,
  input  logic               ld_req_valid,
  input  logic [ENTRY_W-1:0] ld_req_info,
  output logic               ld_req_ready,
  output logic               dc_req_valid,
  output logic               dc_req_is_store,
  output logic [ENTRY_W-1:0] dc_req_info,
  input  logic               dc_req_ready,
  input  logic               dc_rsp_valid,
  input  logic               drain_all,
  output logic               drain_done,
  output logic               busy
);

  localparam logic [CNT_W-1:0] IDLE_THR   = CNT_W'(IDLE_DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] STARVE_THR = CNT_W'(STARVE_LIMIT);

  drain_state_e       state_q, state_d;
  logic [ENTRY_W-1:0] info_q, info_d;
  logic               drain_pend_q, drain_pend_d;

  logic [CNT_W-1:0]   idle_cnt;
  logic [CNT_W-1:0]   starve_cnt;
  logic               in_idle;
  logic               store_go;
  logic               idle_inc, idle_clr;
  logic               starve_inc;

  assign in_idle = (state_q == ST_IDLE);

  // A store is selected only from IDLE and only when one is buffered.
  assign store_go = in_idle && !sb_empty &&
                    (sb_full || drain_pend_q ||
                     (idle_cnt >= IDLE_THR) || (starve_cnt >= STARVE_THR));

  // Load-port idleness: any load request restarts the window; only IDLE cycles count.
  assign idle_clr = ld_req_valid || store_go;
  assign idle_inc = in_idle && !ld_req_valid;

  // A buffered store is starved each time a load takes the port in its place.
  assign starve_inc = in_idle && !sb_empty && !store_go && ld_req_ready;

  sat_counter #(.CNT_W(CNT_W)) u_idle_cnt (
    .clock (clock),
    .reset (reset),
    .inc_i (idle_inc),
    .clr_i (idle_clr),
    .cnt_o (idle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_starve_cnt (
    .clock (clock),
    .reset (reset),
    .inc_i (starve_inc),
    .clr_i (store_go),
    .cnt_o (starve_cnt)
  );

  // Next-state and port muxing for the drain sequencer.
  always_comb begin
    state_d         = state_q;
    info_d          = info_q;
    drain_pend_d    = drain_pend_q || drain_all;
    sb_get_oldest   = 1'b0;
    ld_req_ready    = 1'b0;
    dc_req_valid    = 1'b0;
    dc_req_is_store = 1'b0;
    dc_req_info     = '0;
    drain_done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (store_go) begin
          // Capture the oldest entry now; the buffer may change before the cache accepts.
          info_d  = sb_oldest_info;
          state_d = ST_ISSUE;
        end else if (drain_pend_q) begin
          // Pending drain with nothing selectable means the buffer is empty: fence satisfied.
          // A fresh drain_all in this same cycle re-arms for another pass.
          drain_done   = 1'b1;
          drain_pend_d = drain_all;
        end else begin
          dc_req_valid = ld_req_valid;
          dc_req_info  = ld_req_info;
          ld_req_ready = dc_req_ready && ld_req_valid;
        end
      end

      ST_ISSUE: begin
        dc_req_valid    = 1'b1;
        dc_req_is_store = 1'b1;
        dc_req_info     = info_q;
        if (dc_req_ready) begin
          state_d = ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        if (dc_rsp_valid) begin
          state_d = ST_RETIRE;
        end
      end

      ST_RETIRE: begin
        // Entry leaves the buffer only after the cache confirmed the write.
        sb_get_oldest = 1'b1;
        state_d       = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched store payload and sticky drain request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      info_q       <= '0;
      drain_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      info_q       <= info_d;
      drain_pend_q <= drain_pend_d;
    end
  end

  assign busy = !in_idle;

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl with hand-computed expectations.
// Latency: inputs driven 2 time units after each rising edge, outputs sampled 1 unit later.
// Backpressure: cache ready/response driven per vector.
module tb_store_drain_ctrl;

  localparam int ENTRY_W = 56;

  localparam logic [ENTRY_W-1:0] E0 = 56'hA1_2345_6789_ABCD;
  localparam logic [ENTRY_W-1:0] E1 = 56'h00_DEAD_BEEF_0001;
  localparam logic [ENTRY_W-1:0] E2 = 56'h5C_0F0F_1234_0002;
  localparam logic [ENTRY_W-1:0] E3 = 56'h33_4455_6677_8899;
  localparam logic [ENTRY_W-1:0] E4 = 56'hC0_FFEE_0000_0004;
  localparam logic [ENTRY_W-1:0] E5 = 56'h12_3456_789A_0005;
  localparam logic [ENTRY_W-1:0] E6 = 56'hFE_DCBA_9876_0006;
  localparam logic [ENTRY_W-1:0] L0 = 56'h77_0000_0000_1000;
  localparam logic [ENTRY_W-1:0] L1 = 56'h77_0000_0000_2000;
  localparam logic [ENTRY_W-1:0] L2 = 56'h77_0000_0000_3000;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               sb_empty = 1'b1;
  logic               sb_full = 1'b0;
  logic [ENTRY_W-1:0] sb_oldest_info = '0;
  logic               sb_get_oldest;
  logic               ld_req_valid = 1'b0;
  logic [ENTRY_W-1:0] ld_req_info = '0;
  logic               ld_req_ready;
  logic               dc_req_valid;
  logic               dc_req_is_store;
  logic [ENTRY_W-1:0] dc_req_info;
  logic               dc_req_ready = 1'b0;
  logic               dc_rsp_valid = 1'b0;
  logic               drain_all = 1'b0;
  logic               drain_done;
  logic               busy;

  int checks = 0;
  int errors = 0;

  store_drain_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .sb_empty        (sb_empty),
    .sb_full         (sb_full),
    .sb_oldest_info  (sb_oldest_info),
    .sb_get_oldest   (sb_get_oldest),
    .ld_req_valid    (ld_req_valid),
    .ld_req_info     (ld_req_info),
    .ld_req_ready    (ld_req_ready),
    .dc_req_valid    (dc_req_valid),
    .dc_req_is_store (dc_req_is_store),
    .dc_req_info     (dc_req_info),
    .dc_req_ready    (dc_req_ready),
    .dc_rsp_valid    (dc_rsp_valid),
    .drain_all       (drain_all),
    .drain_done      (drain_done),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #2;
  endtask

  initial begin
    // ---------------- reset ----------------
    nxt();
    nxt();
    #1;
    check("rst_busy",   64'(busy),          64'd0);
    check("rst_pop",    64'(sb_get_oldest), 64'd0);
    check("rst_dcv",    64'(dc_req_valid),  64'd0);
    check("rst_ldrdy",  64'(ld_req_ready),  64'd0);
    check("rst_done",   64'(drain_done),    64'd0);
    check("rst_info",   64'(dc_req_info),   64'd0);
    reset = 1'b0;

    // ---------------- full buffer, zero-wait cache ----------------
    // N: full + load in the same cycle, store wins
    nxt();
    sb_empty = 1'b0; sb_full = 1'b1; sb_oldest_info = E0;
    ld_req_valid = 1'b1; ld_req_info = L0; dc_req_ready = 1'b1;
    #1;
    check("full_n_ldrdy", 64'(ld_req_ready), 64'd0);
    check("full_n_dcv",   64'(dc_req_valid), 64'd0);
    check("full_n_busy",  64'(busy),         64'd0);
    // N+1: request carries the entry seen at N
    nxt();
    sb_oldest_info = E1; ld_req_valid = 1'b0;
    #1;
    check("full_n1_dcv",   64'(dc_req_valid),    64'd1);
    check("full_n1_st",    64'(dc_req_is_store), 64'd1);
    check("full_n1_info",  64'(dc_req_info),     64'(E0));
    // N+2: waiting for response
    nxt();
    dc_rsp_valid = 1'b1;
    #1;
    check("full_n2_dcv",  64'(dc_req_valid),  64'd0);
    check("full_n2_pop",  64'(sb_get_oldest), 64'd0);
    // N+3: pop
    nxt();
    dc_rsp_valid = 1'b0;
    #1;
    check("full_n3_pop",  64'(sb_get_oldest), 64'd1);
    // N+4: back in IDLE, stray response must be ignored
    nxt();
    sb_full = 1'b0; sb_empty = 1'b1; dc_rsp_valid = 1'b1;
    #1;
    check("full_n4_pop",  64'(sb_get_oldest), 64'd0);
    check("full_n4_busy", 64'(busy),          64'd0);
    nxt();
    dc_rsp_valid = 1'b0;
    #1;
    check("stray_rsp_busy", 64'(busy), 64'd0);

    // ---------------- starvation ----------------
    for (int i = 1; i <= 8; i++) begin
      nxt();
      sb_empty = 1'b0; sb_oldest_info = E2;
      ld_req_valid = 1'b1; ld_req_info = L0; dc_req_ready = 1'b1;
      #1;
      check($sformatf("starve_grant%0d", i), 64'(ld_req_ready), 64'd1);
      check($sformatf("starve_info%0d", i),  64'(dc_req_info),  64'(L0));
    end
    nxt();
    #1;
    check("starve9_ldrdy", 64'(ld_req_ready), 64'd0);
    check("starve9_dcv",   64'(dc_req_valid), 64'd0);
    nxt();
    #1;
    check("starve10_st",    64'(dc_req_is_store), 64'd1);
    check("starve10_info",  64'(dc_req_info),     64'(E2));
    check("starve10_ldrdy", 64'(ld_req_ready),    64'd0);
    nxt();
    dc_rsp_valid = 1'b1;
    #1;
    check("starve11_ldrdy", 64'(ld_req_ready), 64'd0);
    check("starve11_busy",  64'(busy),         64'd1);
    nxt();
    dc_rsp_valid = 1'b0;
    #1;
    check("starve12_pop",   64'(sb_get_oldest), 64'd1);
    check("starve12_ldrdy", 64'(ld_req_ready),  64'd0);
    nxt();
    sb_empty = 1'b1;
    #1;
    check("starve13_ldrdy", 64'(ld_req_ready), 64'd1);

    // ---------------- idle-port drain ----------------
    nxt();
    sb_empty = 1'b0; sb_oldest_info = E3; ld_req_info = L1;
    #1;
    check("idle_t0_ldrdy", 64'(ld_req_ready), 64'd1);
    check("idle_t0_info",  64'(dc_req_info),  64'(L1));
    for (int i = 1; i <= 5; i++) begin
      nxt();
      ld_req_valid = 1'b0;
      #1;
      check($sformatf("idle_t%0d_busy", i), 64'(busy),         64'd0);
      check($sformatf("idle_t%0d_dcv", i),  64'(dc_req_valid), 64'd0);
    end
    nxt();
    #1;
    check("idle_t6_busy", 64'(busy),            64'd1);
    check("idle_t6_st",   64'(dc_req_is_store), 64'd1);
    check("idle_t6_info", 64'(dc_req_info),     64'(E3));
    nxt();
    dc_rsp_valid = 1'b1;
    #1;
    nxt();
    dc_rsp_valid = 1'b0;
    #1;
    check("idle_t8_pop", 64'(sb_get_oldest), 64'd1);
    nxt();
    sb_empty = 1'b1;
    #1;
    check("idle_t9_busy", 64'(busy), 64'd0);

    // ---------------- drain_all, two entries, stalled cache ----------------
    nxt();
    sb_empty = 1'b0; sb_oldest_info = E4; drain_all = 1'b1;
    ld_req_valid = 1'b1; ld_req_info = L2; dc_req_ready = 1'b0;
    #1;
    check("drn_d0_done",  64'(drain_done),   64'd0);
    check("drn_d0_ldrdy", 64'(ld_req_ready), 64'd0);
    nxt();
    drain_all = 1'b0;
    #1;
    check("drn_d1_ldrdy", 64'(ld_req_ready), 64'd0);
    check("drn_d1_dcv",   64'(dc_req_valid), 64'd0);
    for (int i = 2; i <= 4; i++) begin
      nxt();
      sb_oldest_info = E5;
      #1;
      check($sformatf("drn_stall%0d_dcv", i),   64'(dc_req_valid), 64'd1);
      check($sformatf("drn_stall%0d_info", i),  64'(dc_req_info),  64'(E4));
      check($sformatf("drn_stall%0d_ldrdy", i), 64'(ld_req_ready), 64'd0);
    end
    nxt();
    dc_req_ready = 1'b1;
    #1;
    check("drn_d5_info", 64'(dc_req_info), 64'(E4));
    nxt();
    dc_req_ready = 1'b0; dc_rsp_valid = 1'b1;
    #1;
    check("drn_d6_dcv",   64'(dc_req_valid), 64'd0);
    check("drn_d6_ldrdy", 64'(ld_req_ready), 64'd0);
    nxt();
    dc_rsp_valid = 1'b0;
    #1;
    check("drn_d7_pop", 64'(sb_get_oldest), 64'd1);
    nxt();
    #1;
    check("drn_d8_busy",  64'(busy),         64'd0);
    check("drn_d8_ldrdy", 64'(ld_req_ready), 64'd0);
    check("drn_d8_done",  64'(drain_done),   64'd0);
    nxt();
    dc_req_ready = 1'b1;
    #1;
    check("drn_d9_info", 64'(dc_req_info),     64'(E5));
    check("drn_d9_st",   64'(dc_req_is_store), 64'd1);
    nxt();
    dc_req_ready = 1'b0; dc_rsp_valid = 1'b1;
    #1;
    check("drn_d10_dcv", 64'(dc_req_valid), 64'd0);
    nxt();
    dc_rsp_valid = 1'b0;
    #1;
    check("drn_d11_pop", 64'(sb_get_oldest), 64'd1);
    nxt();
    sb_empty = 1'b1; dc_req_ready = 1'b1;
    #1;
    check("drn_d12_done",  64'(drain_done),   64'd1);
    check("drn_d12_ldrdy", 64'(ld_req_ready), 64'd0);
    nxt();
    #1;
    check("drn_d13_done",  64'(drain_done),   64'd0);
    check("drn_d13_ldrdy", 64'(ld_req_ready), 64'd1);

    // ---------------- drain_all with empty buffer ----------------
    nxt();
    ld_req_valid = 1'b0; drain_all = 1'b1;
    #1;
    check("empty_f0_done", 64'(drain_done), 64'd0);
    nxt();
    drain_all = 1'b0;
    #1;
    check("empty_f1_done", 64'(drain_done), 64'd1);
    nxt();
    ld_req_valid = 1'b1;
    #1;
    check("empty_f2_done",  64'(drain_done),   64'd0);
    check("empty_f2_ldrdy", 64'(ld_req_ready), 64'd1);

    // ---------------- reset while waiting for response ----------------
    nxt();
    ld_req_valid = 1'b0; ld_req_info = '0;
    sb_empty = 1'b0; sb_full = 1'b1; sb_oldest_info = E6;
    #1;
    check("rstw_r0_busy", 64'(busy), 64'd0);
    nxt();
    #1;
    check("rstw_r1_info", 64'(dc_req_info), 64'(E6));
    nxt();
    reset = 1'b1; dc_req_ready = 1'b0;
    #1;
    check("rstw_r2_busy", 64'(busy),          64'd1);
    check("rstw_r2_pop",  64'(sb_get_oldest), 64'd0);
    nxt();
    reset = 1'b0; dc_rsp_valid = 1'b1; sb_full = 1'b0;
    #1;
    check("rstw_r3_pop",   64'(sb_get_oldest),   64'd0);
    check("rstw_r3_dcv",   64'(dc_req_valid),    64'd0);
    check("rstw_r3_st",    64'(dc_req_is_store), 64'd0);
    check("rstw_r3_info",  64'(dc_req_info),     64'd0);
    check("rstw_r3_ldrdy", 64'(ld_req_ready),    64'd0);
    check("rstw_r3_done",  64'(drain_done),      64'd0);
    check("rstw_r3_busy",  64'(busy),            64'd0);
    nxt();
    dc_rsp_valid = 1'b0;
    #1;
    check("rstw_r4_pop",  64'(sb_get_oldest), 64'd0);
    check("rstw_r4_busy", 64'(busy),          64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
